wm_extract_restore: RTL
=======================

Name: wm_extract_restore

Overview:
- Downstream of the pixel-pair reader/embedder stage. Consumes the two-pixel-per-clock stream that stage produces (watermarked R pairs plus G/B).
- Inverts the difference-expansion embedding on the R channel: recovers the hidden watermark bits and restores the original R pixel values.
- Emits restored RGB pairs, one registered cycle later, for the image writer.

Parameters:
- WIDTH, 8, image width in pixels (even).
- HEIGHT, 8, image height in lines.
- NUM_BITS, 8, watermark bits to recover per frame (1..32).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- VSYNC  in  1  frame start; high for one or more cycles before the first pair.
- HSYNC  in  1  pair valid this cycle.
- WM_R0, WM_R1  in  8  watermarked R, even/odd pixel.
- IN_G0, IN_G1, IN_B0, IN_B1  in  8  G/B pass-through inputs.
- OUT_VALID  out  1  restored pair valid.
- REST_R0, REST_R1  out  8  restored R pair.
- OUT_G0, OUT_G1, OUT_B0, OUT_B1  out  8  G/B delayed one cycle.
- BIT_VALID  out  1  pulse: BIT_OUT carries a recovered bit.
- BIT_OUT  out  1  recovered bit.
- WM_WORD  out  NUM_BITS  collected bits; bit k is the k-th recovered.
- wm_done  out  1  all NUM_BITS bits recovered; held.
- frame_done  out  1  one-cycle pulse after the last pair of the frame.

Behaviour:
- Reset: all outputs 0.
  - State IDLE; bit_cnt, pair_cnt and WM_WORD cleared.
  - Reset mid-frame aborts the frame; nothing resumes.
- Pair count: TOTAL_PAIRS = WIDTH*HEIGHT/2.
- FSM states: IDLE, ARM, EXTRACT, PASS, DONE.
  - IDLE: HSYNC ignored, no output. VSYNC=1 -> ARM.
  - ARM: counters and WM_WORD cleared while VSYNC=1. HSYNC=1 and VSYNC=0 -> EXTRACT; that pair is processed.
  - EXTRACT: every HSYNC pair is decoded. When bit_cnt reaches NUM_BITS -> PASS.
  - PASS: pairs forwarded unchanged (REST = WM).
  - From EXTRACT or PASS: after pair number TOTAL_PAIRS is accepted -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE. wm_done and WM_WORD hold until the next VSYNC or reset.
- VSYNC with HSYNC in the same cycle, in any state: VSYNC wins, counters clear, the pair is dropped, next state ARM.
- Decode, per pair a=WM_R0, b=WM_R1, in EXTRACT:
  - a==b: not a carrier. REST = (a, b), no BIT_VALID, bit_cnt unchanged.
  - a!=b: carrier.
    - d' = |a-b| (8b); bit = d'[0]; d = d'>>1.
    - avg = (a+b)>>1, with the sum computed in 9 bits.
    - hi = avg + ((d+1)>>1); lo = avg - (d>>1).
    - If a>b: REST_R0=hi, REST_R1=lo; otherwise REST_R0=lo, REST_R1=hi.
    - BIT_VALID=1, BIT_OUT=bit, WM_WORD[bit_cnt]=bit, bit_cnt+1.
  - hi and lo are always in 0..255; no saturation logic.
  - Pairs rejected by the embedder's capacity check are not detectable. The first NUM_BITS unequal pairs are treated as carriers.
- Latency and qualification:
  - All outputs are registered; outputs for a pair accepted at edge N appear after edge N+1.
  - OUT_VALID = registered HSYNC, qualified by state EXTRACT/PASS or the ARM->EXTRACT transition.
  - OUT_* and REST_* hold their last value when OUT_VALID=0.
- wm_done rises in the cycle BIT_VALID delivers bit NUM_BITS-1.
- Back-to-back HSYNC at full rate supported, no stalls. HSYNC gaps (line delay) pause counting only.
- Widths: bit_cnt $clog2(NUM_BITS+1); pair_cnt $clog2(TOTAL_PAIRS+1).

Test Plan:
- Decode, a>b: VSYNC, then a pair (100,96) -> next cycle REST=(99,97), BIT_VALID=1, BIT_OUT=0. Pair (101,96) -> REST=(99,97), BIT_OUT=1.
- Decode, a<b, and non-carrier: pair (96,101) -> REST=(97,99), BIT_OUT=1. Pair (50,50) -> REST=(50,50), BIT_VALID=0, bit_cnt unchanged.
- Bit collection and PASS: feed 8 carriers encoding 8'b1011_0010 (bit0 first) and G=B=0x33 -> WM_WORD=8'hB2, wm_done=1 with the 8th BIT_VALID.
  - A 9th unequal pair (101,96) -> REST=(101,96) with no BIT_VALID.
  - OUT_G/B = 0x33 each cycle.
- Frame end: with WIDTH=HEIGHT=8, 32 consecutive HSYNC pairs -> frame_done pulses exactly once, one cycle after the 32nd OUT_VALID. FSM returns to IDLE; further HSYNC produces no OUT_VALID.
- Pair (0,255) -> carrier, bit 1, REST_R0=64, REST_R1=191; outputs stay in 0..255.
- Collision and reset:
  - VSYNC and HSYNC both high mid-frame -> pair dropped, WM_WORD=0, bit_cnt=0.
  - HRESETn low mid-EXTRACT -> all outputs 0 immediately (asynchronous). After release, HSYNC without VSYNC produces no output.

Source files
------------

// File: rtl/wm_extract_restore_if.sv
// Bundle of the pixel-pair stream into and out of the watermark extract/restore stage.
// HSYNC is a valid with no ready: the producer streams pairs at up to one per clock and the stage never stalls.
interface wm_extract_restore_if #(
    parameter int NUM_BITS = 8
);
    logic                VSYNC;
    logic                HSYNC;
    logic [7:0]          WM_R0;
    logic [7:0]          WM_R1;
    logic [7:0]          IN_G0;
    logic [7:0]          IN_G1;
    logic [7:0]          IN_B0;
    logic [7:0]          IN_B1;
    logic                OUT_VALID;
    logic [7:0]          REST_R0;
    logic [7:0]          REST_R1;
    logic [7:0]          OUT_G0;
    logic [7:0]          OUT_G1;
    logic [7:0]          OUT_B0;
    logic [7:0]          OUT_B1;
    logic                BIT_VALID;
    logic                BIT_OUT;
    logic [NUM_BITS-1:0] WM_WORD;
    logic                wm_done;
    logic                frame_done;
    logic [2:0]          dbg_state;

    modport master (
        output VSYNC, HSYNC, WM_R0, WM_R1, IN_G0, IN_G1, IN_B0, IN_B1,
        input  OUT_VALID, REST_R0, REST_R1, OUT_G0, OUT_G1, OUT_B0, OUT_B1,
        input  BIT_VALID, BIT_OUT, WM_WORD, wm_done, frame_done, dbg_state
    );

    modport slave (
        input  VSYNC, HSYNC, WM_R0, WM_R1, IN_G0, IN_G1, IN_B0, IN_B1,
        output OUT_VALID, REST_R0, REST_R1, OUT_G0, OUT_G1, OUT_B0, OUT_B1,
        output BIT_VALID, BIT_OUT, WM_WORD, wm_done, frame_done, dbg_state
    );
endinterface

// File: rtl/wm_extract_restore.sv
// Inverts difference-expansion embedding on the R pair: recovers watermark bits and
// restores the original R values, passing G/B through with one registered cycle.
module wm_extract_restore #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int NUM_BITS = 8
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    wm_extract_restore_if.slave bus
);
    localparam int TOTAL_PAIRS = WIDTH * HEIGHT / 2;
    localparam int BCW = $clog2(NUM_BITS + 1);
    localparam int PCW = $clog2(TOTAL_PAIRS + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARM     = 3'd1;
    localparam logic [2:0] EXTRACT = 3'd2;
    localparam logic [2:0] PASS    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]          state;
    logic [BCW-1:0]      bit_cnt;
    logic [PCW-1:0]      pair_cnt;
    logic                out_valid, bit_valid, bit_out, wm_done, frame_done;
    logic [7:0]          rest_r0, rest_r1, out_g0, out_g1, out_b0, out_b1;
    logic [NUM_BITS-1:0] wm_word;

    logic       accept, carrier, a_gt_b, last_pair, bit_last;
    logic [7:0] diff, avg, hi, lo;

    always_comb begin
        accept    = 1'b0;
        carrier   = 1'b0;
        a_gt_b    = bus.WM_R0 > bus.WM_R1;
        diff      = a_gt_b ? (bus.WM_R0 - bus.WM_R1) : (bus.WM_R1 - bus.WM_R0);
        // floor((a+b)/2) without needing the 9-bit sum's dropped LSB
        avg       = {1'b0, bus.WM_R0[7:1]} + {1'b0, bus.WM_R1[7:1]}
                  + {7'd0, bus.WM_R0[0] & bus.WM_R1[0]};
        // d = diff>>1; hi adds ceil(d/2), lo subtracts floor(d/2)
        hi        = avg + {2'b00, diff[7:2]} + {7'd0, diff[1]};
        lo        = avg - {2'b00, diff[7:2]};
        last_pair = 32'(pair_cnt) == TOTAL_PAIRS - 1;
        bit_last  = 32'(bit_cnt) == NUM_BITS - 1;
        if (!bus.VSYNC && bus.HSYNC && (state == ARM || state == EXTRACT || state == PASS)) begin
            accept  = 1'b1;
            carrier = (state != PASS) && (bus.WM_R0 != bus.WM_R1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            pair_cnt   <= '0;
            out_valid  <= 1'b0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            wm_done    <= 1'b0;
            frame_done <= 1'b0;
            rest_r0    <= '0;
            rest_r1    <= '0;
            out_g0     <= '0;
            out_g1     <= '0;
            out_b0     <= '0;
            out_b1     <= '0;
            wm_word    <= '0;
        end else begin
            frame_done <= (state == DONE);
            out_valid  <= accept;
            bit_valid  <= carrier;
            if (accept) begin
                rest_r0 <= carrier ? (a_gt_b ? hi : lo) : bus.WM_R0;
                rest_r1 <= carrier ? (a_gt_b ? lo : hi) : bus.WM_R1;
                out_g0  <= bus.IN_G0;
                out_g1  <= bus.IN_G1;
                out_b0  <= bus.IN_B0;
                out_b1  <= bus.IN_B1;
            end
            if (carrier) begin
                bit_out <= diff[0];
                for (int k = 0; k < NUM_BITS; k++) begin
                    if (32'(bit_cnt) == k) wm_word[k] <= diff[0];
                end
                bit_cnt <= bit_cnt + BCW'(1);
                if (bit_last) wm_done <= 1'b1;
            end
            // VSYNC restarts the frame from any state; a coincident pair is dropped
            if (bus.VSYNC) begin
                state    <= ARM;
                bit_cnt  <= '0;
                pair_cnt <= '0;
                wm_word  <= '0;
                wm_done  <= 1'b0;
            end else begin
                case (state)
                    ARM, EXTRACT, PASS: begin
                        if (bus.HSYNC) begin
                            pair_cnt <= pair_cnt + PCW'(1);
                            if (last_pair)
                                state <= DONE;
                            else if (state == PASS || (carrier && bit_last))
                                state <= PASS;
                            else
                                state <= EXTRACT;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.OUT_VALID  = out_valid;
    assign bus.REST_R0    = rest_r0;
    assign bus.REST_R1    = rest_r1;
    assign bus.OUT_G0     = out_g0;
    assign bus.OUT_G1     = out_g1;
    assign bus.OUT_B0     = out_b0;
    assign bus.OUT_B1     = out_b1;
    assign bus.BIT_VALID  = bit_valid;
    assign bus.BIT_OUT    = bit_out;
    assign bus.WM_WORD    = wm_word;
    assign bus.wm_done    = wm_done;
    assign bus.frame_done = frame_done;
    assign bus.dbg_state  = state;
endmodule
